perif_switch_reader: RTL and testbench

//  Memory-mapped input peripheral: the read-side counterpart to the 7-segment write-only display

---
 rtl/perif_pkg.sv | 13 +
 rtl/debounce_bit.sv | 36 +++
 rtl/perif_switch_reader.sv | 109 ++++++++++
 tb/tb_perif_switch_reader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/perif_pkg.sv
// rtl/perif_pkg.sv - shared register offsets and I/O counts for the bus peripherals
package perif_pkg;

  localparam int NUM_SW  = 16;
  localparam int NUM_BTN = 5;

  // Byte offsets inside a peripheral's 16-byte window
  localparam logic [3:0] OFF_SW    = 4'h0;
  localparam logic [3:0] OFF_BTN   = 4'h4;
  localparam logic [3:0] OFF_FLAGS = 4'h8;
  localparam logic [3:0] OFF_MASK  = 4'hC;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - per-input debouncer driven by a shared sample tick
module debounce_bit #(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_tick,
  input  logic din_sync,
  output logic dout,
  output logic rise
);

  logic [3:0] cnt;
  logic       accept;

  // rise fires in the cycle dout is about to go 0->1, so event capture lines up with the level
  assign accept = sample_tick && (din_sync != dout) && (cnt == 4'(STABLE_SAMPLES - 1));
  assign rise   = accept && din_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (sample_tick) begin
      if (din_sync == dout) begin
        cnt <= '0;
      end else if (accept) begin
        dout <= din_sync;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/perif_switch_reader.sv
// rtl/perif_switch_reader.sv - debounced switch/button input peripheral with sticky press flags
module perif_switch_reader
  import perif_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_2000,
  parameter int          SAMPLE_DIV     = 100000,
  parameter int          STABLE_SAMPLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw,
  input  logic [4:0]  btn,
  input  logic [31:0] address,
  input  logic        WE,
  input  logic        RE,
  input  logic [31:0] dataout,
  output logic [31:0] datain,
  output logic        rvalid,
  output logic        irq
);

  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [NUM_SW-1:0]  sw_s1, sw_s2, sw_deb, sw_rise;
  logic [NUM_BTN-1:0] btn_s1, btn_s2, btn_deb, btn_rise;
  logic [NUM_BTN-1:0] flags, flags_n, irq_mask;
  logic [PW-1:0]      presc;
  logic               sample_tick;
  logic               in_win, wr_flags, wr_mask;
  logic [3:0]         off;
  logic [31:0]        rd_val;
  logic               unused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
    end
  end

  assign sample_tick = (presc == PW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              presc <= '0;
    else if (sample_tick) presc <= '0;
    else                  presc <= presc + PW'(1);
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_bit #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_deb (
      .clk(clk), .rst(rst), .sample_tick(sample_tick),
      .din_sync(sw_s2[i]), .dout(sw_deb[i]), .rise(sw_rise[i])
    );
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_bit #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_deb (
      .clk(clk), .rst(rst), .sample_tick(sample_tick),
      .din_sync(btn_s2[i]), .dout(btn_deb[i]), .rise(btn_rise[i])
    );
  end

  assign in_win   = (address[31:4] == BASE_ADDR[31:4]);
  assign off      = {address[3:2], 2'b00};
  assign wr_flags = WE && in_win && (off == OFF_FLAGS);
  assign wr_mask  = WE && in_win && (off == OFF_MASK);

  // A press landing on the same edge as a W1C wins over the clear
  assign flags_n = (flags & ~(wr_flags ? dataout[NUM_BTN-1:0] : '0)) | btn_rise;

  always_comb begin
    rd_val = '0;
    if (in_win) begin
      case (off)
        OFF_SW:    rd_val = {{(32-NUM_SW){1'b0}}, sw_deb};
        OFF_BTN:   rd_val = {{(32-NUM_BTN){1'b0}}, btn_deb};
        OFF_FLAGS: rd_val = {{(32-NUM_BTN){1'b0}}, flags};
        OFF_MASK:  rd_val = {{(32-NUM_BTN){1'b0}}, irq_mask};
        default:   rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags    <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
      rvalid   <= 1'b0;
      datain   <= '0;
    end else begin
      flags  <= flags_n;
      irq    <= |(flags & irq_mask);
      rvalid <= RE;
      if (wr_mask) irq_mask <= dataout[NUM_BTN-1:0];
      if (RE)      datain   <= rd_val;
    end
  end

  assign unused = &{1'b0, address[1:0], dataout[31:NUM_BTN], sw_rise};

endmodule

// File: tb/tb_perif_switch_reader.sv
// tb/tb_perif_switch_reader.sv - directed self-checking bench for perif_switch_reader
module tb_perif_switch_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic [4:0]  btn;
  logic [31:0] address;
  logic        WE, RE;
  logic [31:0] dataout;
  logic [31:0] datain;
  logic        rvalid, irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] tb_presc;

  perif_switch_reader #(
    .BASE_ADDR(32'h0000_2000), .SAMPLE_DIV(4), .STABLE_SAMPLES(3)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn), .address(address),
    .WE(WE), .RE(RE), .dataout(dataout), .datain(datain),
    .rvalid(rvalid), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference sample phase: counts 0..3 from reset, tick in the cycle holding 3
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tb_presc <= 2'd0;
    else     tb_presc <= tb_presc + 2'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    address = addr;
    RE = 1'b1;
    tick();
    RE = 1'b0;
    check({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
    check(tag, datain, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    address = addr;
    dataout = data;
    WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  // Press btn[idx]; return inside the cycle whose closing edge raises its debounced level
  task automatic wait_rise(input int idx);
    int k;
    btn[idx] = 1'b1;
    tick();
    tick();
    k = 0;
    for (int n = 0; n < 40; n++) begin
      if (tb_presc == 2'd3) k++;
      if (k == 3) break;
      tick();
    end
    if (k != 3) check("wait_rise_timeout", k, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sw = '0; btn = '0; address = '0;
    WE = 1'b0; RE = 1'b0; dataout = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset mid-run
    wr(32'h200C, 32'h1);
    btn[0] = 1'b1;
    repeat (20) tick();
    check("irq_pre_reset", {31'b0, irq}, 32'd1);
    rd(32'h2008, 32'h1, "flags_pre_reset");
    rst = 1'b1;
    #1;
    check("rst_datain", datain, 32'h0);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    btn = '0;
    tick(); tick();
    rst = 1'b0;
    repeat (20) tick();
    rd(32'h2000, 32'h0, "rst_sw");
    rd(32'h2004, 32'h0, "rst_btn");
    rd(32'h2008, 32'h0, "rst_flags");
    rd(32'h200C, 32'h0, "rst_mask");

    // Debounce
    sw = 16'hA5C3;
    repeat (20) tick();
    rd(32'h2000, 32'h0000_A5C3, "sw_level");
    sw[0] = 1'b0;
    tick();
    sw[0] = 1'b1;
    repeat (20) tick();
    rd(32'h2000, 32'h0000_A5C3, "sw_glitch");

    // Press + W1C
    btn[2] = 1'b1;
    repeat (20) tick();
    rd(32'h2004, 32'h4, "btn_level");
    btn[2] = 1'b0;
    repeat (20) tick();
    rd(32'h2008, 32'h4, "flag_set");
    rd(32'h2004, 32'h0, "btn_released");
    wr(32'h2008, 32'h0);
    rd(32'h2008, 32'h4, "w1c_zero_keeps");
    wr(32'h2008, 32'h4);
    rd(32'h2008, 32'h0, "w1c_clears");

    // IRQ latency
    wr(32'h200C, 32'h1F);
    rd(32'h200C, 32'h1F, "mask_rb");
    wait_rise(0);
    check("irq_before", {31'b0, irq}, 32'd0);
    tick();
    check("irq_lag", {31'b0, irq}, 32'd0);
    tick();
    check("irq_set", {31'b0, irq}, 32'd1);
    wr(32'h2008, 32'h1);
    check("irq_hold", {31'b0, irq}, 32'd1);
    tick();
    check("irq_clear", {31'b0, irq}, 32'd0);
    btn[0] = 1'b0;
    repeat (20) tick();

    // Collision: W1C on the edge the press lands
    wait_rise(1);
    address = 32'h2008;
    dataout = 32'h2;
    WE = 1'b1;
    tick();
    WE = 1'b0;
    rd(32'h2008, 32'h2, "collision_set_wins");
    address = 32'h2008;
    dataout = 32'h2;
    WE = 1'b1;
    RE = 1'b1;
    tick();
    WE = 1'b0;
    RE = 1'b0;
    check("rw_pre_value", datain, 32'h2);
    rd(32'h2008, 32'h0, "rw_write_done");
    btn[1] = 1'b0;
    repeat (20) tick();

    // Bus behaviour
    rd(32'h2010, 32'h0, "unmapped_2010");
    tick();
    check("rvalid_one_pulse", {31'b0, rvalid}, 32'd0);
    rd(32'h3000, 32'h0, "outside_3000");
    rd(32'h2000, 32'h0000_A5C3, "sw_again");
    tick();
    check("datain_hold", datain, 32'h0000_A5C3);
    address = 32'h2004;
    RE = 1'b1;
    tick();
    check("b2b_1_rvalid", {31'b0, rvalid}, 32'd1);
    check("b2b_1_data", datain, 32'h0);
    address = 32'h2000;
    tick();
    RE = 1'b0;
    check("b2b_2_rvalid", {31'b0, rvalid}, 32'd1);
    check("b2b_2_data", datain, 32'h0000_A5C3);
    tick();
    check("b2b_end_rvalid", {31'b0, rvalid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
